// File: rtl/cpu_step_ctrl.sv
// Execution-rate controller for the CPU pipeline: turns board mode/step inputs and
// core halt requests into a single-cycle clock-enable pulse on the system clock.
module cpu_step_ctrl #(
  parameter int          DIV_W   = 32,
  parameter int unsigned DEF_DIV = 5000000,
  parameter int          BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               step_req,
  input  logic [DIV_W-1:0]   div_val,
  input  logic               div_load,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  output logic               cpu_ce,
  output logic [1:0]         state,
  output logic               busy,
  output logic               burst_done
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_div;
  logic [BURST_W-1:0] r_burst_rem;
  logic               r_step_prev;
  logic               r_ce;
  logic               r_done;

  logic               w_step_edge;
  logic               w_tick;
  logic               w_abort;
  logic [DIV_W-1:0]   w_div_new;

  assign w_step_edge = step_req & ~r_step_prev;
  assign w_tick      = (r_state != S_HALT) && (r_cnt == r_div - 1'b1);
  assign w_abort     = ((r_state == S_RUN) && (mode != 2'b01)) ||
                       ((r_state == S_BURST) && (mode == 2'b00));
  // A zero divisor would never tick; clamp it to the fastest rate instead.
  assign w_div_new   = (div_val == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HALT;
      r_cnt       <= '0;
      r_div       <= DIV_W'(DEF_DIV);
      r_burst_rem <= '0;
      r_step_prev <= 1'b1;
      r_ce        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_step_prev <= step_req;
      r_ce        <= 1'b0;
      r_done      <= 1'b0;
      if (div_load)
        r_div <= w_div_new;

      case (r_state)
        S_HALT: begin
          r_cnt <= '0;
          if (!halt_req) begin
            case (mode)
              2'b01: r_state <= S_RUN;
              2'b10: if (w_step_edge) r_ce <= 1'b1;
              2'b11: begin
                if (w_step_edge && (burst_len != '0)) begin
                  r_burst_rem <= burst_len;
                  r_state     <= S_BURST;
                end
              end
              default: ;
            endcase
          end
        end

        default: begin
          if (halt_req) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (div_load) begin
            // New divisor restarts the period; the pending tick is dropped.
            r_cnt <= '0;
            if (w_abort)
              r_state <= S_HALT;
          end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            r_ce  <= w_tick;
            if ((r_state == S_BURST) && w_tick) begin
              r_burst_rem <= r_burst_rem - 1'b1;
              if ((r_burst_rem == BURST_W'(1)) && !w_abort) begin
                r_done  <= 1'b1;
                r_state <= S_HALT;
                r_cnt   <= '0;
              end
            end
            if (w_abort) begin
              r_state <= S_HALT;
              r_cnt   <= '0;
            end
          end
        end
      endcase
    end
  end

  assign cpu_ce     = r_ce;
  assign burst_done = r_done;
  assign state      = r_state;
  assign busy       = (r_state != S_HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: a cycle model of the rate rules is compared every
// cycle, and hand-computed pulse counts/latencies pin the model itself.
module tb_cpu_step_ctrl;

  localparam int          DIV_W   = 32;
  localparam int          BURST_W = 16;
  localparam int unsigned DEF_DIV = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         mode = 2'b00;
  logic               step_req = 1'b0;
  logic [DIV_W-1:0]   div_val = '0;
  logic               div_load = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               halt_req = 1'b0;
  logic               cpu_ce;
  logic [1:0]         state;
  logic               busy;
  logic               burst_done;

  int passes = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int win_ce = 0;
  int win_done = 0;
  int win_both = 0;

  cpu_step_ctrl #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_req(step_req), .div_val(div_val),
    .div_load(div_load), .burst_len(burst_len), .halt_req(halt_req),
    .cpu_ce(cpu_ce), .state(state), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  // Model: activity mode (0 halt, 1 run, 2 burst), cycles elapsed in the current
  // period window, divisor, pulses left in the burst.
  int     m_st = 0;
  longint m_el = 0;
  longint m_div = DEF_DIV;
  int     m_left = 0;
  bit     m_prev = 1'b1;
  bit     e_ce = 1'b0;
  bit     e_done = 1'b0;

  always @(posedge clk) begin : model_p
    int st; longint el; longint dv; int left;
    bit ce; bit dn; bit edge_s; bit tick; bit abort_s;
    st = m_st; el = m_el; dv = m_div; left = m_left; ce = 1'b0; dn = 1'b0;
    edge_s = step_req && !m_prev;
    if (rst) begin
      st = 0; el = 0; dv = DEF_DIV; left = 0;
      m_prev <= 1'b1;
    end else begin
      m_prev <= step_req;
      tick = (st != 0) && ((el % dv) == dv - 1);
      abort_s = (st == 1 && mode != 2'd1) || (st == 2 && mode == 2'd0);
      if (div_load) dv = (div_val == '0) ? 64'd1 : longint'(div_val);
      if (st == 0) begin
        el = 0;
        if (!halt_req) begin
          if (mode == 2'd1) st = 1;
          else if (mode == 2'd2 && edge_s) ce = 1'b1;
          else if (mode == 2'd3 && edge_s && burst_len != '0) begin
            left = int'(burst_len);
            st = 2;
          end
        end
      end else if (halt_req) begin
        st = 0; el = 0;
      end else if (div_load) begin
        el = 0;
        if (abort_s) st = 0;
      end else begin
        ce = tick;
        if (st == 2 && tick) begin
          left = left - 1;
          if (left == 0 && !abort_s) begin dn = 1'b1; st = 0; end
        end
        if (abort_s) st = 0;
        el = (st == 0) ? 0 : el + 1;
      end
    end
    m_st <= st; m_el <= el; m_div <= dv; m_left <= left;
    e_ce <= ce; e_done <= dn;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
  endtask

  initial begin : cmp_p
    wait (cmp_en);
    forever begin
      @(negedge clk);
      chk("cyc_ce", longint'(cpu_ce), longint'(e_ce));
      chk("cyc_done", longint'(burst_done), longint'(e_done));
      chk("cyc_state", longint'(state), longint'(m_st));
      chk("cyc_busy", longint'(busy), longint'(m_st != 0));
    end
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      win_ce   += int'(cpu_ce);
      win_done += int'(burst_done);
      win_both += int'(cpu_ce & burst_done);
    end
  endtask

  task automatic clr_win();
    win_ce = 0; win_done = 0; win_both = 0;
  endtask

  task automatic load_div(input int v);
    div_val = DIV_W'(v);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  initial begin : main_p
    repeat (3) @(negedge clk);
    chk("rst_ce", longint'(cpu_ce), 0);
    chk("rst_state", longint'(state), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(burst_done), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Free run at the default divisor of 4.
    mode = 2'b01;
    @(negedge clk);
    chk("run_state", longint'(state), 1);
    clr_win(); tick_n(3);
    chk("run_no_early_ce", win_ce, 0);
    @(negedge clk);
    chk("run_first_ce_5", longint'(cpu_ce), 1);
    clr_win(); tick_n(3);
    chk("run_gap", win_ce, 0);
    @(negedge clk);
    chk("run_period_4", longint'(cpu_ce), 1);
    clr_win(); tick_n(16);
    chk("run_16cyc_ce", win_ce, 4);
    mode = 2'b00;
    tick_n(3);
    chk("run_to_halt", longint'(state), 0);

    // Single-step: three presses, each held 10 cycles.
    mode = 2'b10;
    clr_win();
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      @(negedge clk);
      chk("step_ce_latency", longint'(cpu_ce), 1);
      win_ce += int'(cpu_ce);
      tick_n(9);
      step_req = 1'b0;
      tick_n(10);
    end
    chk("step_ce_count", win_ce, 3);
    chk("step_state", longint'(state), 0);

    // Burst of 5 at divisor 2, twice.
    mode = 2'b00;
    load_div(2);
    burst_len = BURST_W'(5);
    mode = 2'b11;
    step_req = 1'b1;
    clr_win(); tick_n(14);
    chk("burst1_ce", win_ce, 5);
    chk("burst1_done", win_done, 1);
    chk("burst1_done_with_ce", win_both, 1);
    chk("burst1_state", longint'(state), 0);
    step_req = 1'b0;
    tick_n(1);
    step_req = 1'b1;
    clr_win(); tick_n(14);
    chk("burst2_ce", win_ce, 5);
    chk("burst2_done", win_done, 1);
    step_req = 1'b0;
    mode = 2'b00;

    // halt_req on the cycle the tick would fire, divisor 8.
    load_div(8);
    mode = 2'b01;
    clr_win(); tick_n(8);
    chk("halt_pre_ce", win_ce, 0);
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_tick_suppressed", longint'(cpu_ce), 0);
    chk("halt_state", longint'(state), 0);
    clr_win(); tick_n(5);
    chk("halt_blocks_run", win_ce, 0);
    chk("halt_blocks_state", longint'(state), 0);
    mode = 2'b00;
    halt_req = 1'b0;
    clr_win(); tick_n(20);
    chk("halt_no_more_ce", win_ce, 0);

    // Load divisor 0 mid-period at divisor 8: clamps to 1.
    mode = 2'b01;
    tick_n(4);
    div_val = '0;
    div_load = 1'b1;
    @(negedge clk);
    chk("load_suppresses", longint'(cpu_ce), 0);
    div_load = 1'b0;
    clr_win(); tick_n(10);
    chk("div1_every_cycle", win_ce, 10);
    mode = 2'b00;
    tick_n(3);

    // Zero-length burst is a no-op.
    mode = 2'b11;
    burst_len = '0;
    step_req = 1'b1;
    clr_win(); tick_n(10);
    chk("burst0_ce", win_ce, 0);
    chk("burst0_state", longint'(state), 0);
    step_req = 1'b0;
    mode = 2'b00;

    // Burst of 100 at divisor 3, reset after the 10th pulse.
    load_div(3);
    burst_len = BURST_W'(100);
    mode = 2'b11;
    step_req = 1'b1;
    clr_win();
    for (int i = 0; i < 400 && win_ce < 10; i++) tick_n(1);
    chk("burst100_reach_10", win_ce, 10);
    rst = 1'b1;
    @(negedge clk);
    win_ce += int'(cpu_ce);
    chk("mid_rst_ce", longint'(cpu_ce), 0);
    chk("mid_rst_state", longint'(state), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_done", longint'(burst_done), 0);
    rst = 1'b0;
    tick_n(20);
    chk("burst100_total_ce", win_ce, 10);
    chk("held_button_no_edge", longint'(state), 0);
    mode = 2'b00;
    step_req = 1'b0;
    tick_n(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
